i2s_clkgen: RTL and testbench

I2S_CLKGEN -- requirements
Module: i2s_clkgen

---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_lock_qual.sv | 63 ++++++
 rtl/i2s_clkgen.sv | 165 ++++++++++++++++
 tb/tb_i2s_clkgen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg -- shared definitions for the I2S master clock generator.
//
// Holds the generator FSM state type, the default divider / slot-width /
// lock-settle constants, and a small helper that identifies the states in
// which the bit and word clocks are being produced.
package i2s_pkg;

  // Generator states. WAIT_LOCK and SETTLE qualify the PLL lock; IDLE waits
  // for enable; RUN and DRAIN both produce clocks (DRAIN finishes the frame).
  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_IDLE      = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } i2s_state_e;

  // 12.288 MHz master clock / 4 = 3.072 MHz bit clock (48 kHz, 2 x 32 bits).
  localparam int I2S_BCLK_DIV_DEFAULT    = 4;
  localparam int I2S_SLOT_BITS_DEFAULT   = 32;
  localparam int I2S_LOCK_SETTLE_DEFAULT = 1024;

  // True in the states where bclk/lrclk are toggling.
  function automatic logic i2s_is_active(input i2s_state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/i2s_lock_qual.sv
// i2s_lock_qual -- PLL lock synchronizer and settle qualifier.
//
// Brings the asynchronous PLL lock flag into the clk domain with a two-flop
// synchronizer and counts consecutive cycles in which the synchronized flag
// is high. lock_ok is asserted in the cycle that completes LOCK_SETTLE
// consecutive high cycles and stays asserted while the lock holds; any low
// cycle restarts the count from zero.
//
// Ports:
//   clk        in   master clock
//   rst        in   asynchronous active-high reset
//   pll_locked in   PLL lock flag, asynchronous to clk
//   lock_s     out  synchronized lock flag
//   lock_ok    out  lock has been continuously high for LOCK_SETTLE cycles
module i2s_lock_qual
  import i2s_pkg::*;
#(
  parameter int LOCK_SETTLE = I2S_LOCK_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_s,
  output logic lock_ok
);

  localparam int CNT_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_SETTLE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of consecutive high lock_s cycles already
  // completed, saturating at LOCK_SETTLE-1; the current high cycle is the
  // one that makes up the full count, hence the combinational lock_ok.
  always_comb begin
    sync1_d = pll_locked;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lock_s  = sync2_q;
  assign lock_ok = sync2_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/i2s_clkgen.sv
// i2s_clkgen -- I2S master bit-clock / word-clock generator.
//
// Divides the audio master clock into a 50% duty bit clock and derives the
// left/right word select from a frame bit counter. Generation starts only
// after the PLL lock has been stable for LOCK_SETTLE cycles and enable is
// high; when enable drops the current frame is completed before stopping.
// Losing lock stops everything on the following cycle.
//
// Ports:
//   clk         in   audio master clock (sole clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to clk
//   enable      in   request to generate clocks
//   bclk        out  bit clock
//   lrclk       out  word select, 0 = left slot, 1 = right slot
//   bclk_rise   out  one-cycle strobe in the cycle bclk goes high
//   bclk_fall   out  one-cycle strobe in the cycle bclk goes low
//   frame_start out  strobe with bclk_fall at bit 0 of the left slot
//   bit_idx     out  bit position within the frame, 0..2*SLOT_BITS-1
//   running     out  high while clocks are being generated
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV    = I2S_BCLK_DIV_DEFAULT,
  parameter int SLOT_BITS   = I2S_SLOT_BITS_DEFAULT,
  parameter int LOCK_SETTLE = I2S_LOCK_SETTLE_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pll_locked,
  input  logic                           enable,
  output logic                           bclk,
  output logic                           lrclk,
  output logic                           bclk_rise,
  output logic                           bclk_fall,
  output logic                           frame_start,
  output logic [$clog2(2*SLOT_BITS)-1:0] bit_idx,
  output logic                           running
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);

  logic lock_s;
  logic lock_ok;

  i2s_lock_qual #(
    .LOCK_SETTLE (LOCK_SETTLE)
  ) u_lock_qual (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .lock_s     (lock_s),
    .lock_ok    (lock_ok)
  );

  i2s_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             bclk_q, bclk_d;
  logic             bclk_rise_q, bclk_rise_d;
  logic             bclk_fall_q, bclk_fall_d;
  logic             frame_start_q, frame_start_d;
  logic             running_q, running_d;

  logic             active_now;
  logic             active_next;
  logic             bit_end;
  logic             frame_end;

  // Next-state logic.
  always_comb begin
    active_now = i2s_is_active(state_q);
    bit_end    = active_now && (div_cnt_q == DIV_LAST);
    frame_end  = bit_end && (bit_idx_q == BIT_LAST);

    state_d = state_q;
    case (state_q)
      ST_WAIT_LOCK: if (lock_s) state_d = ST_SETTLE;
      ST_SETTLE:    if (lock_ok) state_d = ST_IDLE;
      ST_IDLE:      if (enable) state_d = ST_RUN;
      // Dropping enable exactly on the last cycle of a frame stops cleanly
      // instead of draining a whole extra frame.
      ST_RUN:       if (!enable) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
        end else if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_WAIT_LOCK;
    endcase

    // Lock loss overrides everything, abandoning any frame in progress.
    if (!lock_s) begin
      state_d = ST_WAIT_LOCK;
    end
  end

  // Counters and outputs. Every output is registered from the next-cycle
  // counter values, so the first RUN cycle already shows div_cnt = 0
  // (bclk low, bclk_fall, frame_start) and lock loss clears them together
  // with the state change.
  always_comb begin
    active_next = i2s_is_active(state_d);
    div_cnt_d   = '0;
    bit_idx_d   = '0;

    if (active_next && active_now) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        // 2*SLOT_BITS is a power of two, so the natural wrap is the frame wrap.
        bit_idx_d = bit_idx_q + BIT_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bit_idx_d = bit_idx_q;
      end
    end

    running_d     = active_next;
    bclk_d        = active_next && (div_cnt_d >= DIV_HALF);
    bclk_fall_d   = active_next && (div_cnt_d == '0);
    bclk_rise_d   = active_next && (div_cnt_d == DIV_HALF);
    // A DRAIN frame wrap goes to IDLE, so only RUN may start a new frame.
    frame_start_d = bclk_fall_d && (bit_idx_d == '0) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      div_cnt_q     <= '0;
      bit_idx_q     <= '0;
      bclk_q        <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_idx_q     <= bit_idx_d;
      bclk_q        <= bclk_d;
      bclk_rise_q   <= bclk_rise_d;
      bclk_fall_q   <= bclk_fall_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign bclk        = bclk_q;
  assign bclk_rise   = bclk_rise_q;
  assign bclk_fall   = bclk_fall_q;
  assign frame_start = frame_start_q;
  assign bit_idx     = bit_idx_q;
  // Word select follows the frame counter MSB, so it can only change when
  // bit_idx advances, i.e. on a bclk falling edge.
  assign lrclk       = bit_idx_q[BIT_W-1];
  assign running     = running_q;

endmodule

// File: tb/tb_i2s_clkgen.sv
// tb_i2s_clkgen -- self-checking bench for i2s_clkgen at default parameters.
//
// A reference model updated on every rising clock edge derives the expected
// outputs from a frame position counter using plain arithmetic and pushes
// them into a queue; a monitor on the falling edge pops and compares.
// Directed sequences additionally measure latencies and periods.
module tb_i2s_clkgen;

  localparam int DIV    = 4;
  localparam int SB     = 32;
  localparam int SETTLE = 1024;
  localparam int FRAME  = DIV * 2 * SB;
  localparam int BW     = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          enable = 1'b0;
  logic          bclk, lrclk, bclk_rise, bclk_fall, frame_start, running;
  logic [BW-1:0] bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_clkgen dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .enable      (enable),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .bclk_rise   (bclk_rise),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start),
    .bit_idx     (bit_idx),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output word {running,bclk,lrclk,rise,fall,frame_start,bit_idx}
  // for a generator that is (or is not) active at frame position t.
  function automatic logic [11:0] model_out(input bit gen, input int t);
    int ph;
    int bitn;
    ph   = t % DIV;
    bitn = t / DIV;
    if (!gen) return 12'h000;
    return {1'b1, ph >= DIV / 2, bitn >= SB, ph == DIV / 2, ph == 0, t == 0, 6'(bitn)};
  endfunction

  // Reference model.
  logic [11:0] exp_q[$];
  bit m_s1 = 0, m_s2 = 0, m_ready = 0, m_gen = 0;
  int m_lock_run = 0;
  int m_t = 0;

  always @(posedge clk) begin
    bit lock_now;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lock_run = 0; m_ready = 0; m_gen = 0; m_t = 0;
    end else begin
      lock_now = m_s2;
      m_s2     = m_s1;
      m_s1     = pll_locked;
      if (!lock_now) begin
        m_lock_run = 0; m_ready = 0; m_gen = 0; m_t = 0;
      end else begin
        m_lock_run++;
        if (m_gen) begin
          // Stop only at the end of a frame with enable low; otherwise keep going.
          if (m_t == FRAME - 1 && !enable) begin
            m_gen = 0; m_t = 0;
          end else begin
            m_t = (m_t + 1) % FRAME;
          end
        end else if (m_ready && enable) begin
          m_gen = 1; m_t = 0;
        end
        m_ready = (m_lock_run >= SETTLE);
      end
    end
    exp_q.push_back(model_out(m_gen, m_t));
  end

  // Monitor.
  bit prev_lr = 0, prev_run = 0;
  always @(negedge clk) begin
    logic [11:0] a;
    logic [11:0] e;
    a = {running, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got %h, expected %h", $time, a, e);
      end
    end
    if (running && prev_run && (lrclk != prev_lr)) begin
      n_checks++;
      if (bclk_fall !== 1'b1) begin
        n_fail++;
        $display("FAIL lrclk_on_fall t=%0t: bclk_fall=%b, expected 1", $time, bclk_fall);
      end
    end
    prev_lr  = lrclk;
    prev_run = running;
  end

  // Wait (sampling 1 time unit after each rising edge) for an event:
  // 0 running high, 1 running low, 2 frame_start, 3 bclk_rise, 4 bit_idx==10.
  task automatic wait_sig(input int which, input int budget, output int cyc);
    bit hit;
    cyc = 0;
    hit = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      case (which)
        0:       hit = (running === 1'b1);
        1:       hit = (running === 1'b0);
        2:       hit = (frame_start === 1'b1);
        3:       hit = (bclk_rise === 1'b1);
        4:       hit = (bit_idx === 6'd10);
        default: hit = 1;
      endcase
    end while (!hit && cyc < budget);
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%0d: no event within %0d cycles", which, budget);
    end
  endtask

  initial begin
    int cyc;
    int fs_cnt;
    int pll_low;

    rst = 1'b1; pll_locked = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {running, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Start-up latency and first RUN cycle.
    wait_sig(0, 3000, cyc);
    check("startup_latency", cyc, 2 + SETTLE + 1);
    check("first_frame_start", frame_start, 1);
    check("first_bclk_fall", bclk_fall, 1);
    check("first_bclk", bclk, 0);
    check("first_bit_idx", bit_idx, 0);

    // Periods.
    wait_sig(2, 1000, cyc);
    check("frame_period", cyc, FRAME);
    wait_sig(3, 100, cyc);
    wait_sig(3, 100, cyc);
    check("bclk_period", cyc, DIV);

    // Drain: enable drops at bit 10, frame completes with no new frame_start.
    wait_sig(4, 1000, cyc);
    enable = 1'b0;
    cyc = 0; fs_cnt = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (frame_start) fs_cnt++;
    end while (running && cyc < 1000);
    check("drain_cycles", cyc, FRAME - 10 * DIV);
    check("drain_frame_start", fs_cnt, 0);
    check("drain_idle_clocks", {bclk, lrclk, bit_idx}, 0);

    // Restart from IDLE takes one cycle.
    enable = 1'b1;
    wait_sig(0, 10, cyc);
    check("restart_latency", cyc, 1);
    repeat (100) @(posedge clk);
    #1;

    // Lock loss mid-frame, then relock.
    pll_locked = 1'b0;
    wait_sig(1, 20, cyc);
    check("lock_loss_latency", cyc, 3);
    check("lock_loss_outputs", {bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx}, 0);
    pll_locked = 1'b1;
    wait_sig(0, 3000, cyc);
    check("relock_latency", cyc, 2 + SETTLE + 1);

    // One-cycle glitch partway through settling restarts the count.
    pll_locked = 1'b0;
    wait_sig(1, 20, cyc);
    repeat (10) @(posedge clk);
    #1;
    pll_locked = 1'b1;
    repeat (502) @(posedge clk);
    #1;
    pll_locked = 1'b0;
    @(posedge clk); #1;
    pll_locked = 1'b1;
    wait_sig(0, 3000, cyc);
    check("glitch_relock_latency", cyc, 2 + SETTLE + 1);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    repeat (50) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {running, bclk, lrclk, bclk_rise, bclk_fall, frame_start, bit_idx}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_sig(0, 3000, cyc);
    check("post_reset_settle", cyc, 2 + SETTLE + 1);

    // Randomized enable toggling and occasional short lock drops.
    pll_low = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if (pll_low > 0) begin
        pll_low--;
        if (pll_low == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 2499) == 0) begin
        pll_locked = 1'b0;
        pll_low = $urandom_range(1, 5);
      end
    end
    pll_locked = 1'b1;
    enable = 1'b0;
    repeat (4) @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
